// File: rtl/control_sequencer_if.sv
// Interface between the hardwired control sequencer and the CPU datapath.
//  master : the control sequencer (drives strobes, Run, pc_reset_val, state_dbg;
//           receives IR, CON_FF, Stop)
//  slave  : the datapath side (the mirror image)
// Signals:
//  IR, CON_FF, Stop            datapath/system inputs to the sequencer
//  Run, pc_reset_val           processor run flag and reset-PC constant
//  *out                        bus-source selects (at most one high at a time)
//  *in                         register load enables
//  IncPC..BAout                miscellaneous datapath controls
//  state_dbg                   current sequencer state, for observation only
// Handshake: there is no valid/ready pair here. Every output is a level that is
// valid for the whole clock cycle of the state that produces it, and every
// input is sampled on the rising clock edge.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        Stop;
  logic        Run;
  logic [31:0] pc_reset_val;
  logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout;
  logic        MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, OutPortin;
  logic        IncPC, MD_read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [3:0]  state_dbg;

  modport master (
    input  IR, CON_FF, Stop,
    output Run, pc_reset_val,
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
    output MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, OutPortin,
    output IncPC, MD_read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
    output state_dbg
  );

  modport slave (
    output IR, CON_FF, Stop,
    input  Run, pc_reset_val,
    input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
    input  MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, OutPortin,
    input  IncPC, MD_read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
    input  state_dbg
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle hardwired control unit for the CPU datapath.
// Steps one T-state per clock: fetch T0-T2, then a class-dependent execute
// sequence T3..T7 decoded from the opcode IR[OPC_MSB -: 5]. Owns run/halt.
// Ports:
//  clock  in  system clock, all state on posedge
//  clear  in  synchronous active-high reset (back to state RESET)
//  bus    control_sequencer_if.master: IR/CON_FF/Stop in, all strobes out
module control_sequencer #(
  parameter int          OPC_MSB  = 31,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_BR, C_JR,
    C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } class_e;

  state_e     state, state_next;
  class_e     cls;
  state_e     last_state;
  logic       stop_pend;
  logic [4:0] opcode;

  assign opcode           = bus.IR[OPC_MSB -: 5];
  assign bus.pc_reset_val = RESET_PC;
  assign bus.state_dbg    = state;
  assign bus.Run          = (state != S_RESET) && (state != S_HALT);

  // Opcode class. IR is only reloaded at the end of T2, so this decode is
  // stable for the whole execute phase; during fetch it is simply unused.
  always_comb begin
    cls = C_NOP;
    case (opcode)
      5'b00000: cls = C_LD;
      5'b00001: cls = C_LDI;
      5'b00010: cls = C_ST;
      5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000: cls = C_ALU;
      5'b01001, 5'b01010, 5'b01011: cls = C_IMM;
      5'b01100, 5'b01101: cls = C_MULDIV;
      5'b01110: cls = C_BR;
      5'b01111: cls = C_JR;
      5'b10000: cls = C_IN;
      5'b10001: cls = C_OUT;
      5'b10010: cls = C_MFHI;
      5'b10011: cls = C_MFLO;
      5'b11011: cls = C_HALT;
      default:  cls = C_NOP;
    endcase
  end

  // Final execute state of each class.
  always_comb begin
    last_state = S_T3;
    case (cls)
      C_LD, C_ST:            last_state = S_T7;
      C_LDI, C_ALU, C_IMM:   last_state = S_T5;
      C_MULDIV, C_BR:        last_state = S_T6;
      default:               last_state = S_T3;
    endcase
  end

  // State register and halt-request latch. clear overrides everything,
  // including a Stop arriving on the same edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= S_RESET;
      stop_pend <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_HALT)
        stop_pend <= 1'b0;
      else if (bus.Stop && (state != S_RESET) && (state != S_HALT))
        stop_pend <= 1'b1;
    end
  end

  // Next-state logic. Stop is honoured only at an instruction boundary; a Stop
  // seen on the boundary edge itself still counts for the finishing instruction.
  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state == last_state) begin
          if (cls == C_HALT || stop_pend || bus.Stop)
            state_next = S_HALT;
          else
            state_next = S_T0;
        end else begin
          case (state)
            S_T3:    state_next = S_T4;
            S_T4:    state_next = S_T5;
            S_T5:    state_next = S_T6;
            S_T6:    state_next = S_T7;
            default: state_next = S_T0;
          endcase
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
  end

  // Strobe decode: everything low unless the current state lists it.
  always_comb begin
    bus.PCout     = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.MDRout    = 1'b0;
    bus.HIout     = 1'b0;
    bus.LOout     = 1'b0;
    bus.InPortout = 1'b0;
    bus.Cout      = 1'b0;
    bus.MARin     = 1'b0;
    bus.PCin      = 1'b0;
    bus.MDRin     = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zlowin    = 1'b0;
    bus.Zhighin   = 1'b0;
    bus.HIin      = 1'b0;
    bus.LOin      = 1'b0;
    bus.OutPortin = 1'b0;
    bus.IncPC     = 1'b0;
    bus.MD_read   = 1'b0;
    bus.Write     = 1'b0;
    bus.Gra       = 1'b0;
    bus.Grb       = 1'b0;
    bus.Grc       = 1'b0;
    bus.Rin       = 1'b0;
    bus.Rout      = 1'b0;
    bus.BAout     = 1'b0;

    case (state)
      S_T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.MD_read = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (cls)
          // ld / ldi / st share the effective-address computation in T3-T4.
          C_LD, C_LDI, C_ST: begin
            case (state)
              S_T3: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
              S_T4: begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; end
              S_T5: begin
                bus.Zlowout = 1'b1;
                if (cls == C_LDI) begin
                  bus.Gra = 1'b1;
                  bus.Rin = 1'b1;
                end else begin
                  bus.MARin = 1'b1;
                end
              end
              S_T6: begin
                if (cls == C_LD) begin
                  bus.MD_read = 1'b1;
                  bus.MDRin   = 1'b1;
                end else if (cls == C_ST) begin
                  bus.Gra   = 1'b1;
                  bus.Rout  = 1'b1;
                  bus.MDRin = 1'b1;
                end
              end
              S_T7: begin
                if (cls == C_LD) begin
                  bus.MDRout = 1'b1;
                  bus.Gra    = 1'b1;
                  bus.Rin    = 1'b1;
                end else if (cls == C_ST) begin
                  bus.Write = 1'b1;
                end
              end
              default: ;
            endcase
          end
          C_ALU, C_IMM: begin
            case (state)
              S_T3: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
              S_T4: begin
                bus.Zlowin = 1'b1;
                if (cls == C_ALU) begin
                  bus.Grc  = 1'b1;
                  bus.Rout = 1'b1;
                end else begin
                  bus.Cout = 1'b1;
                end
              end
              S_T5: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              default: ;
            endcase
          end
          C_MULDIV: begin
            case (state)
              S_T3: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
              S_T4: begin
                bus.Grb     = 1'b1;
                bus.Rout    = 1'b1;
                bus.Zlowin  = 1'b1;
                bus.Zhighin = 1'b1;
              end
              S_T5: begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
              S_T6: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
              default: ;
            endcase
          end
          C_BR: begin
            case (state)
              // T3 puts Ra on the bus so the datapath can evaluate CON_FF.
              S_T3: begin bus.Gra = 1'b1; bus.Rout = 1'b1; end
              S_T4: begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
              S_T5: begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; end
              S_T6: begin bus.Zlowout = 1'b1; bus.PCin = bus.CON_FF; end
              default: ;
            endcase
          end
          C_JR: if (state == S_T3) begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
          end
          C_IN: if (state == S_T3) begin
            bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          C_OUT: if (state == S_T3) begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1;
          end
          C_MFHI: if (state == S_T3) begin
            bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          C_MFLO: if (state == S_T3) begin
            bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  localparam int W = 28;

  localparam logic [W-1:0] PCOUT     = 28'h1 << 0;
  localparam logic [W-1:0] ZLOWOUT   = 28'h1 << 1;
  localparam logic [W-1:0] ZHIGHOUT  = 28'h1 << 2;
  localparam logic [W-1:0] MDROUT    = 28'h1 << 3;
  localparam logic [W-1:0] HIOUT     = 28'h1 << 4;
  localparam logic [W-1:0] LOOUT     = 28'h1 << 5;
  localparam logic [W-1:0] INPORTOUT = 28'h1 << 6;
  localparam logic [W-1:0] COUT      = 28'h1 << 7;
  localparam logic [W-1:0] MARIN     = 28'h1 << 8;
  localparam logic [W-1:0] PCIN      = 28'h1 << 9;
  localparam logic [W-1:0] MDRIN     = 28'h1 << 10;
  localparam logic [W-1:0] IRIN      = 28'h1 << 11;
  localparam logic [W-1:0] YIN       = 28'h1 << 12;
  localparam logic [W-1:0] ZLOWIN    = 28'h1 << 13;
  localparam logic [W-1:0] ZHIGHIN   = 28'h1 << 14;
  localparam logic [W-1:0] HIIN      = 28'h1 << 15;
  localparam logic [W-1:0] LOIN      = 28'h1 << 16;
  localparam logic [W-1:0] OUTPORTIN = 28'h1 << 17;
  localparam logic [W-1:0] INCPC     = 28'h1 << 18;
  localparam logic [W-1:0] MD_READ   = 28'h1 << 19;
  localparam logic [W-1:0] WRITE     = 28'h1 << 20;
  localparam logic [W-1:0] GRA       = 28'h1 << 21;
  localparam logic [W-1:0] GRB       = 28'h1 << 22;
  localparam logic [W-1:0] GRC       = 28'h1 << 23;
  localparam logic [W-1:0] RIN       = 28'h1 << 24;
  localparam logic [W-1:0] ROUT      = 28'h1 << 25;
  localparam logic [W-1:0] BAOUT     = 28'h1 << 26;
  localparam logic [W-1:0] RUN       = 28'h1 << 27;

  // clock / reset
  logic clock;
  logic clear;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  control_sequencer_if bus_if ();

  control_sequencer #(.OPC_MSB(31), .RESET_PC(32'h0)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus_if)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  function automatic logic [W-1:0] observed();
    return {bus_if.Run, bus_if.BAout, bus_if.Rout, bus_if.Rin, bus_if.Grc,
            bus_if.Grb, bus_if.Gra, bus_if.Write, bus_if.MD_read, bus_if.IncPC,
            bus_if.OutPortin, bus_if.LOin, bus_if.HIin, bus_if.Zhighin,
            bus_if.Zlowin, bus_if.Yin, bus_if.IRin, bus_if.MDRin, bus_if.PCin,
            bus_if.MARin, bus_if.Cout, bus_if.InPortout, bus_if.LOout,
            bus_if.HIout, bus_if.MDRout, bus_if.Zhighout, bus_if.Zlowout,
            bus_if.PCout};
  endfunction

  // At most one bus source may drive the bus in any cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      logic [7:0] src;
      src = observed() & 28'hFF;
      checks++;
      assert ($onehot0(src)) else begin
        errors++;
        $error("FAIL bus_onehot: observed %b required at most one bit set", src);
      end
    end
  end

  // driver tasks
  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic push_fetch();
    push(RUN | PCOUT | MARIN | INCPC | ZLOWIN);
    push(RUN | ZLOWOUT | PCIN | MD_READ | MDRIN);
    push(RUN | MDROUT | IRIN);
  endtask

  task automatic check_cycle(input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    @(posedge clock);
    #1;
    obs_v = observed();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h required an expectation in the queue", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
      end
    end
  endtask

  // Runs one instruction of 'cycles' clocks (fetch included). IR is loaded
  // after T0 has been checked so it never changes under an execute state.
  task automatic do_instr(input string name, input logic [31:0] ir,
                          input logic con, input int cycles);
    check_cycle($sformatf("%s_c0", name));
    bus_if.IR     = ir;
    bus_if.CON_FF = con;
    for (int i = 1; i < cycles; i++)
      check_cycle($sformatf("%s_c%0d", name, i));
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc);
    return {opc, 27'(($urandom_range(0, 32'h07FF_FFFF)))};
  endfunction

  initial begin
    clear         = 1'b1;
    bus_if.IR     = 32'h0;
    bus_if.CON_FF = 1'b0;
    bus_if.Stop   = 1'b0;

    // reset: two clocks in clear, Run and all strobes low
    push(0); push(0);
    check_cycle("clear_0");
    check_cycle("clear_1");
    clear  = 1'b0;
    mon_en = 1'b1;

    // add (exact opcode word), 6 cycles
    push_fetch();
    push(RUN | GRB | ROUT | YIN); push(RUN | GRC | ROUT | ZLOWIN); push(RUN | ZLOWOUT | GRA | RIN);
    do_instr("add", 32'h1800_0000, 1'b0, 6);

    // ld, 8 cycles; MD_read only in T1 and T6
    push_fetch();
    push(RUN | GRB | BAOUT | YIN); push(RUN | COUT | ZLOWIN); push(RUN | ZLOWOUT | MARIN);
    push(RUN | MD_READ | MDRIN); push(RUN | MDROUT | GRA | RIN);
    do_instr("ld", mk_ir(5'b00000), 1'b0, 8);

    // ldi
    push_fetch();
    push(RUN | GRB | BAOUT | YIN); push(RUN | COUT | ZLOWIN); push(RUN | ZLOWOUT | GRA | RIN);
    do_instr("ldi", mk_ir(5'b00001), 1'b0, 6);

    // st
    push_fetch();
    push(RUN | GRB | BAOUT | YIN); push(RUN | COUT | ZLOWIN); push(RUN | ZLOWOUT | MARIN);
    push(RUN | GRA | ROUT | MDRIN); push(RUN | WRITE);
    do_instr("st", mk_ir(5'b00010), 1'b0, 8);

    // reg ALU upper end (shr)
    push_fetch();
    push(RUN | GRB | ROUT | YIN); push(RUN | GRC | ROUT | ZLOWIN); push(RUN | ZLOWOUT | GRA | RIN);
    do_instr("shr", mk_ir(5'b01000), 1'b0, 6);

    // imm ALU both ends
    push_fetch();
    push(RUN | GRB | ROUT | YIN); push(RUN | COUT | ZLOWIN); push(RUN | ZLOWOUT | GRA | RIN);
    do_instr("addi", mk_ir(5'b01001), 1'b0, 6);
    push_fetch();
    push(RUN | GRB | ROUT | YIN); push(RUN | COUT | ZLOWIN); push(RUN | ZLOWOUT | GRA | RIN);
    do_instr("ori", mk_ir(5'b01011), 1'b0, 6);

    // mul / div
    push_fetch();
    push(RUN | GRA | ROUT | YIN); push(RUN | GRB | ROUT | ZLOWIN | ZHIGHIN);
    push(RUN | ZLOWOUT | LOIN); push(RUN | ZHIGHOUT | HIIN);
    do_instr("mul", mk_ir(5'b01100), 1'b0, 7);
    push_fetch();
    push(RUN | GRA | ROUT | YIN); push(RUN | GRB | ROUT | ZLOWIN | ZHIGHIN);
    push(RUN | ZLOWOUT | LOIN); push(RUN | ZHIGHOUT | HIIN);
    do_instr("div", mk_ir(5'b01101), 1'b0, 7);

    // br not taken, then taken
    push_fetch();
    push(RUN | GRA | ROUT); push(RUN | PCOUT | YIN); push(RUN | COUT | ZLOWIN); push(RUN | ZLOWOUT);
    do_instr("br_nt", mk_ir(5'b01110), 1'b0, 7);
    push_fetch();
    push(RUN | GRA | ROUT); push(RUN | PCOUT | YIN); push(RUN | COUT | ZLOWIN); push(RUN | ZLOWOUT | PCIN);
    do_instr("br_t", mk_ir(5'b01110), 1'b1, 7);

    // single-state classes
    push_fetch(); push(RUN | GRA | ROUT | PCIN);
    do_instr("jr", mk_ir(5'b01111), 1'b0, 4);
    push_fetch(); push(RUN | INPORTOUT | GRA | RIN);
    do_instr("in", mk_ir(5'b10000), 1'b0, 4);
    push_fetch(); push(RUN | GRA | ROUT | OUTPORTIN);
    do_instr("out", mk_ir(5'b10001), 1'b0, 4);
    push_fetch(); push(RUN | HIOUT | GRA | RIN);
    do_instr("mfhi", mk_ir(5'b10010), 1'b0, 4);
    push_fetch(); push(RUN | LOOUT | GRA | RIN);
    do_instr("mflo", mk_ir(5'b10011), 1'b0, 4);
    push_fetch(); push(RUN);
    do_instr("nop", mk_ir(5'b11010), 1'b0, 4);
    push_fetch(); push(RUN);
    do_instr("undef", mk_ir(5'b11111), 1'b0, 4);

    // Stop pulsed during T4 of an add: add completes, then HALT
    push_fetch();
    push(RUN | GRB | ROUT | YIN); push(RUN | GRC | ROUT | ZLOWIN); push(RUN | ZLOWOUT | GRA | RIN);
    push(0); push(0); push(0);
    check_cycle("stop_t0");
    bus_if.IR = mk_ir(5'b00011);
    check_cycle("stop_t1");
    check_cycle("stop_t2");
    check_cycle("stop_t3");
    check_cycle("stop_t4");
    bus_if.Stop = 1'b1;
    check_cycle("stop_t5");
    bus_if.Stop = 1'b0;
    check_cycle("stop_halt0");
    check_cycle("stop_halt1");
    check_cycle("stop_halt2");

    // leave HALT via clear
    clear = 1'b1;
    push(0);
    check_cycle("halt_clear");
    clear = 1'b0;

    // halt opcode: empty T3 then HALT
    push_fetch(); push(RUN); push(0); push(0);
    do_instr("halt", mk_ir(5'b11011), 1'b0, 6);

    // clear together with Stop: clear wins, no pending halt afterwards
    clear       = 1'b1;
    bus_if.Stop = 1'b1;
    push(0);
    check_cycle("clr_stop");
    clear       = 1'b0;
    bus_if.Stop = 1'b0;
    push_fetch();
    push(RUN | GRB | ROUT | YIN); push(RUN | GRC | ROUT | ZLOWIN); push(RUN | ZLOWOUT | GRA | RIN);
    do_instr("add_after_clr", mk_ir(5'b00100), 1'b0, 6);

    // clear in place of T5 of ld: no partial completion, restart in T0
    push_fetch();
    push(RUN | GRB | BAOUT | YIN); push(RUN | COUT | ZLOWIN);
    push(0);
    check_cycle("ldclr_t0");
    bus_if.IR = mk_ir(5'b00000);
    check_cycle("ldclr_t1");
    check_cycle("ldclr_t2");
    check_cycle("ldclr_t3");
    check_cycle("ldclr_t4");
    clear = 1'b1;
    check_cycle("ldclr_reset");
    clear = 1'b0;
    push_fetch();
    push(RUN | GRB | ROUT | YIN); push(RUN | GRC | ROUT | ZLOWIN); push(RUN | ZLOWOUT | GRA | RIN);
    do_instr("add_restart", mk_ir(5'b00011), 1'b0, 6);

    // the instruction boundary after the last add returns to T0
    push(RUN | PCOUT | MARIN | INCPC | ZLOWIN);
    check_cycle("final_t0");

    mon_en = 1'b0;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: observed %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
